// File: rtl/systolic_feeder_pkg.sv
// Shared constants and state encoding for the systolic array feeder.
package systolic_feeder_pkg;

    localparam int DEF_DATA_SIZE = 4;
    localparam int DEF_N = 4;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FEED,
        ST_DONE
    } state_t;

    function automatic int feed_cycles(input int n);
        return 3 * n - 2;
    endfunction

endpackage

// File: rtl/systolic_feeder_buf.sv
// Operand buffer: N rows of A and N rows of B, one write port, all rows readable.
module matrix_buf
    import systolic_feeder_pkg::*;
#(
    parameter int DATA_SIZE = DEF_DATA_SIZE,
    parameter int N = DEF_N,
    localparam int RW = N * DATA_SIZE,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic          wr_sel,
    input  logic [IW-1:0] wr_row,
    input  logic [RW-1:0] wr_data,
    output logic [RW-1:0] a_rows [N],
    output logic [RW-1:0] b_rows [N]
);

    logic row_ok;

    // Out-of-range row indices are silently dropped.
    assign row_ok = (int'(wr_row) < N);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < N; r++) begin
                a_rows[r] <= '0;
                b_rows[r] <= '0;
            end
        end else if (wr_en && row_ok) begin
            if (wr_sel == SEL_A) begin
                a_rows[wr_row] <= wr_data;
            end else if (wr_sel == SEL_B) begin
                b_rows[wr_row] <= wr_data;
            end
        end
    end

endmodule

// File: rtl/systolic_feeder.sv
// Skewed A/B edge feeder for an NxN systolic multiplier.
// Define FEEDER_RUN_COUNT_EN to add the run_count output.
module systolic_feeder
    import systolic_feeder_pkg::*;
#(
    parameter int DATA_SIZE = DEF_DATA_SIZE,
    parameter int N = DEF_N
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic                   load_sel,
    input  logic [$clog2(N)-1:0]   load_row,
    input  logic [N*DATA_SIZE-1:0] load_data,
    input  logic                   start,
    output logic                   busy,
    output logic                   pe_clear,
    output logic [N*DATA_SIZE-1:0] a_out,
    output logic [N*DATA_SIZE-1:0] b_out,
    output logic                   result_valid
`ifdef FEEDER_RUN_COUNT_EN
    ,
    output logic [15:0]            run_count
`endif
);

    localparam int RW = N * DATA_SIZE;
    localparam int FEED_CYCLES = feed_cycles(N);
    localparam int STEP_W = $clog2(FEED_CYCLES);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(FEED_CYCLES - 1);

    state_t            state;
    logic [STEP_W-1:0] step;
    logic [STEP_W-1:0] sk_step;
    logic [RW-1:0]     a_rows [N];
    logic [RW-1:0]     b_rows [N];
    logic [RW-1:0]     a_skew;
    logic [RW-1:0]     b_skew;
    logic              wr_en;

    assign wr_en = load_valid && load_ready;

    matrix_buf #(
        .DATA_SIZE (DATA_SIZE),
        .N         (N)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_sel  (load_sel),
        .wr_row  (load_row),
        .wr_data (load_data),
        .a_rows  (a_rows),
        .b_rows  (b_rows)
    );

    // Outputs are registered, so the mux looks one step ahead.
    assign sk_step = (state == ST_FEED) ? step + 1'b1 : '0;

    always_comb begin
        a_skew = '0;
        b_skew = '0;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                if (int'(sk_step) == i + k) begin
                    a_skew[i*DATA_SIZE +: DATA_SIZE] =
                        a_rows[i][k*DATA_SIZE +: DATA_SIZE];
                    b_skew[i*DATA_SIZE +: DATA_SIZE] =
                        b_rows[k][i*DATA_SIZE +: DATA_SIZE];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            step         <= '0;
            load_ready   <= 1'b1;
            busy         <= 1'b0;
            pe_clear     <= 1'b0;
            result_valid <= 1'b0;
            a_out        <= '0;
            b_out        <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_CLEAR;
                        step       <= '0;
                        busy       <= 1'b1;
                        load_ready <= 1'b0;
                        pe_clear   <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    state    <= ST_FEED;
                    pe_clear <= 1'b0;
                    a_out    <= a_skew;
                    b_out    <= b_skew;
                end
                ST_FEED: begin
                    if (step == LAST_STEP) begin
                        state        <= ST_DONE;
                        a_out        <= '0;
                        b_out        <= '0;
                        result_valid <= 1'b1;
                    end else begin
                        step  <= step + 1'b1;
                        a_out <= a_skew;
                        b_out <= b_skew;
                    end
                end
                ST_DONE: begin
                    state        <= ST_IDLE;
                    result_valid <= 1'b0;
                    busy         <= 1'b0;
                    load_ready   <= 1'b1;
                end
            endcase
        end
    end

`ifdef FEEDER_RUN_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_count <= '0;
        end else if (state == ST_DONE) begin
            run_count <= run_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Randomized bench for systolic_feeder with a behavioural 4x4 PE grid downstream.
module tb_systolic_feeder;

    localparam int N = 4;
    localparam int DS = 4;
    localparam int RUN = 3 * N;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_valid;
    logic        load_ready;
    logic        load_sel;
    logic [1:0]  load_row;
    logic [15:0] load_data;
    logic        start;
    logic        busy;
    logic        pe_clear;
    logic [15:0] a_out;
    logic [15:0] b_out;
    logic        result_valid;
`ifdef FEEDER_RUN_COUNT_EN
    logic [15:0] run_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int runs = 0;
    int ma [N][N];
    int mb [N][N];
    int sa [N][N];
    int sb [N][N];

    logic [3:0] ha  [N][N];
    logic [3:0] vb  [N][N];
    logic [8:0] acc [N][N];

    systolic_feeder #(.DATA_SIZE(DS), .N(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_sel     (load_sel),
        .load_row     (load_row),
        .load_data    (load_data),
        .start        (start),
        .busy         (busy),
        .pe_clear     (pe_clear),
        .a_out        (a_out),
        .b_out        (b_out),
        .result_valid (result_valid)
`ifdef FEEDER_RUN_COUNT_EN
        ,
        .run_count    (run_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] in_a(int i, int j);
        return (j == 0) ? a_out[i*DS +: DS] : ha[i][j-1];
    endfunction

    function automatic logic [3:0] in_b(int i, int j);
        return (i == 0) ? b_out[j*DS +: DS] : vb[i-1][j];
    endfunction

    // Downstream PE grid: a flows right, b flows down, 9-bit wrapping accumulators.
    always @(posedge clk or posedge reset) begin
        if (reset || pe_clear) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    ha[i][j]  <= '0;
                    vb[i][j]  <= '0;
                    acc[i][j] <= '0;
                end
        end else begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    acc[i][j] <= acc[i][j] + 9'(in_a(i, j)) * 9'(in_b(i, j));
                    ha[i][j]  <= in_a(i, j);
                    vb[i][j]  <= in_b(i, j);
                end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_a(int t);
        logic [15:0] v = '0;
        for (int i = 0; i < N; i++)
            if (t - i >= 0 && t - i < N) v[i*DS +: DS] = 4'(ma[i][t-i]);
        return v;
    endfunction

    function automatic logic [15:0] exp_b(int t);
        logic [15:0] v = '0;
        for (int j = 0; j < N; j++)
            if (t - j >= 0 && t - j < N) v[j*DS +: DS] = 4'(mb[t-j][j]);
        return v;
    endfunction

    function automatic int exp_c(int i, int j);
        int s = 0;
        for (int k = 0; k < N; k++) s += ma[i][k] * mb[k][j];
        return s % 512;
    endfunction

    function automatic void model_write(logic sel, int row, logic [15:0] d);
        for (int k = 0; k < N; k++) begin
            if (sel) mb[row][k] = int'(d[k*DS +: DS]);
            else     ma[row][k] = int'(d[k*DS +: DS]);
        end
    endfunction

    task automatic load_row_t(input logic sel, input int row, input logic [15:0] d);
        @(negedge clk);
        chk("load_ready_idle", 32'(load_ready), 32'd1);
        load_valid = 1'b1;
        load_sel   = sel;
        load_row   = 2'(row);
        load_data  = d;
        @(posedge clk);
        model_write(sel, row, d);
        #1 load_valid = 1'b0;
    endtask

    task automatic load_stage();
        logic [15:0] d;
        for (int r = 0; r < N; r++) begin
            for (int k = 0; k < N; k++) d[k*DS +: DS] = 4'(sa[r][k]);
            load_row_t(1'b0, r, d);
            for (int k = 0; k < N; k++) d[k*DS +: DS] = 4'(sb[r][k]);
            load_row_t(1'b1, r, d);
        end
    endtask

    task automatic stage_random();
        for (int r = 0; r < N; r++)
            for (int k = 0; k < N; k++) begin
                sa[r][k] = int'($urandom_range(0, 15));
                sb[r][k] = int'($urandom_range(0, 15));
            end
    endtask

    task automatic do_run(input bit ld, input logic sel, input int row,
                          input logic [15:0] d, input bit inject);
        @(negedge clk);
        start      = 1'b1;
        load_valid = ld;
        load_sel   = sel;
        load_row   = 2'(row);
        load_data  = d;
        @(posedge clk);
        if (ld) model_write(sel, row, d);
        #1;
        start      = 1'b0;
        load_valid = 1'b0;
        for (int n = 1; n <= RUN + 1; n++) begin
            @(negedge clk);
            chk("busy", 32'(busy), 32'(n <= RUN));
            chk("load_ready", 32'(load_ready), 32'(n > RUN));
            chk("pe_clear", 32'(pe_clear), 32'(n == 1));
            chk("result_valid", 32'(result_valid), 32'(n == RUN));
            chk("a_out", 32'(a_out), (n >= 2 && n < RUN) ? 32'(exp_a(n - 2)) : 32'd0);
            chk("b_out", 32'(b_out), (n >= 2 && n < RUN) ? 32'(exp_b(n - 2)) : 32'd0);
            if (n == RUN)
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++)
                        chk("out_c", 32'(acc[i][j]), 32'(exp_c(i, j)));
            start      = inject && (n == 4 || n == RUN);
            load_valid = inject && (n == 4);
            load_sel   = 1'b0;
            load_row   = 2'd0;
            load_data  = 16'($urandom);
        end
        start      = 1'b0;
        load_valid = 1'b0;
        runs++;
        @(negedge clk);
        chk("no_rerun", 32'(busy), 32'd0);
`ifdef FEEDER_RUN_COUNT_EN
        chk("run_count", 32'(run_count), 32'(runs));
`endif
    endtask

    task automatic reset_mid_run();
        int rv_seen = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (7) @(negedge clk);
        chk("pre_reset_a", 32'(a_out), 32'(exp_a(5)));
        reset = 1'b1;
        #1;
        chk("reset_a", 32'(a_out), 32'd0);
        chk("reset_b", 32'(b_out), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_ready", 32'(load_ready), 32'd1);
        for (int r = 0; r < N; r++)
            for (int k = 0; k < N; k++) begin
                ma[r][k] = 0;
                mb[r][k] = 0;
            end
        runs = 0;
        @(negedge clk);
        reset = 1'b0;
        repeat (RUN + 4) begin
            @(negedge clk);
            if (result_valid || busy) rv_seen++;
        end
        chk("no_rv_after_reset", 32'(rv_seen), 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        load_valid = 1'b0;
        load_sel   = 1'b0;
        load_row   = '0;
        load_data  = '0;
        start      = 1'b0;
        for (int r = 0; r < N; r++)
            for (int k = 0; k < N; k++) begin
                ma[r][k] = 0;
                mb[r][k] = 0;
            end
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(load_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_clear", 32'(pe_clear), 32'd0);
        chk("rst_rv", 32'(result_valid), 32'd0);
        chk("rst_a", 32'(a_out), 32'd0);
        chk("rst_b", 32'(b_out), 32'd0);
        reset = 1'b0;

        // Identity times B
        for (int r = 0; r < N; r++)
            for (int k = 0; k < N; k++) begin
                sa[r][k] = (r == k) ? 1 : 0;
                sb[r][k] = (4 * r + k + 1) % 16;
            end
        load_stage();
        do_run(1'b0, 1'b0, 0, 16'd0, 1'b0);

        // Distinct skew pattern
        stage_random();
        for (int r = 0; r < N; r++)
            for (int k = 0; k < N; k++) sa[r][k] = 4 * r + k;
        load_stage();
        do_run(1'b0, 1'b0, 0, 16'd0, 1'b0);

        // Saturated operands, accumulator wraps
        for (int r = 0; r < N; r++)
            for (int k = 0; k < N; k++) begin
                sa[r][k] = 15;
                sb[r][k] = 15;
            end
        load_stage();
        do_run(1'b0, 1'b0, 0, 16'd0, 1'b0);

        // Mid-run start/load ignored, then rerun on unchanged buffer
        stage_random();
        load_stage();
        do_run(1'b0, 1'b0, 0, 16'd0, 1'b1);
        do_run(1'b0, 1'b0, 0, 16'd0, 1'b0);

        // Reset mid-FEED, then rerun on the cleared buffer
        stage_random();
        load_stage();
        reset_mid_run();
        do_run(1'b0, 1'b0, 0, 16'd0, 1'b0);

        // Same-cycle load and start
        stage_random();
        load_stage();
        do_run(1'b1, 1'b1, 0, 16'h7777, 1'b0);

        for (int it = 0; it < 3; it++) begin
            stage_random();
            load_stage();
            do_run(1'b0, 1'b0, 0, 16'd0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
